// File: rtl/pipe_drain_buffer_pkg.sv
// Shared definitions for the pipe drain buffer: width helpers and FSM encoding.
package pipe_drain_buffer_pkg;

  // Ceiling log2; clog2(1) = 0. Usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((int'(1) << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Credit counter and FIFO count must represent 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return clog2(depth + 1);
  endfunction

  // Pointer addresses 0..depth-1; keep at least one bit for depth 1.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  // Flush counter holds latency down to 1.
  function automatic int flush_width(input int latency);
    return (latency > 1) ? clog2(latency + 1) : 1;
  endfunction

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_drain_fifo.sv
// Synchronous FIFO with occupancy count and arbitrary (non-power-of-2) depth.
// A write while full is only accepted when a read frees a slot in the same
// cycle; otherwise it is dropped and flagged on the drop output.
module pipe_drain_fifo
  import pipe_drain_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic [credit_width(DEPTH)-1:0] count,
  output logic                           drop
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = credit_width(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             empty;
  logic             do_rd;
  logic             do_wr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign drop    = wr_en && full && !do_rd;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_rd) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/pipe_drain_buffer.sv
// Reader end of a fixed-latency, non-stallable pipe. Issue into the pipe is
// credit-gated so every result has a guaranteed buffer slot; buffered results
// drain through a valid/ready master port. After reset, a flush window of
// LATENCY cycles discards results that were already in flight.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FLUSH | issue blocked, pipe results ignored, counting down LATENCY
// ST_RUN   | normal credit-gated issue and buffered drain
module pipe_drain_buffer
  import pipe_drain_buffer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LATENCY    = 8,
  parameter int FIFO_DEPTH = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [WIDTH-1:0]                    s_data,
  output logic                                p_in_valid,
  output logic [WIDTH-1:0]                    p_in_data,
  input  logic                                p_out_valid,
  input  logic [WIDTH-1:0]                    p_out_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [WIDTH-1:0]                    m_data,
  output logic [credit_width(FIFO_DEPTH)-1:0] credits,
  output logic                                overflow
);

  localparam int CW = credit_width(FIFO_DEPTH);
  localparam int FW = flush_width(LATENCY);
  localparam logic [CW-1:0] CRED_MAX   = CW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(LATENCY);

  if (LATENCY < 1) begin : g_bad_latency
    $error("pipe_drain_buffer: LATENCY must be at least 1");
  end
  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("pipe_drain_buffer: FIFO_DEPTH must be at least 1");
  end

  state_t        state;
  state_t        state_next;
  logic [FW-1:0] flush_cnt;
  logic [FW-1:0] flush_cnt_next;
  logic          run;
  logic          fire;
  logic          pop;
  logic          fifo_wr;
  logic          fifo_drop;
  logic [CW-1:0] fifo_count;

  // FSM state and flush counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FLUSH;
      flush_cnt <= FLUSH_INIT;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Next-state logic: flush counts down to 1, then run until reset.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    run            = 1'b0;
    case (state)
      ST_FLUSH: begin
        if (flush_cnt == FW'(1)) begin
          state_next = ST_RUN;
        end else begin
          flush_cnt_next = flush_cnt - 1'b1;
        end
      end
      ST_RUN: begin
        run = 1'b1;
      end
      default: begin
        state_next = ST_FLUSH;
      end
    endcase
  end

  // s_ready depends only on registered state, never on s_valid or m_ready.
  assign s_ready    = run && (credits != '0);
  assign fire       = s_valid && s_ready;
  assign p_in_valid = fire;
  assign p_in_data  = s_data;

  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign fifo_wr = p_out_valid && run;

  // Credits: one consumed per issue, one returned per drained result.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CRED_MAX;
    end else begin
      case ({fire, pop})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          assert (credits != CRED_MAX);
          if (credits != CRED_MAX) begin
            credits <= credits + 1'b1;
          end
        end
        default: credits <= credits;
      endcase
    end
  end

  // Sticky record of any pipe result lost to a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

  // Free credits and buffered entries together never exceed the buffer size.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(credits) + int'(fifo_count) <= FIFO_DEPTH);
    end
  end

  pipe_drain_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (p_out_data),
    .rd_en   (pop),
    .rd_data (m_data),
    .count   (fifo_count),
    .drop    (fifo_drop)
  );

endmodule

// File: tb/tb_pipe_drain_buffer.sv
// Self-checking bench: external pipe model plus a queue-based reference model.
module tb_pipe_drain_buffer;
  import pipe_drain_buffer_pkg::*;

  localparam int WIDTH   = 8;
  localparam int LATENCY = 8;
  localparam int DEPTH   = 10;
  localparam int CW      = credit_width(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             p_in_valid;
  logic [WIDTH-1:0] p_in_data;
  logic             p_out_valid;
  logic [WIDTH-1:0] p_out_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [CW-1:0]    credits;
  logic             overflow;

  logic               inject;
  logic [WIDTH-1:0]   inj_data;
  logic [LATENCY-1:0] pv = '0;
  logic [WIDTH-1:0]   pd [LATENCY];

  // Reference model state
  int               since_rel;
  int               mcred;
  logic [WIDTH-1:0] fq[$];
  bit               movf;
  bit               m_fire;
  bit               m_pop;
  logic [WIDTH-1:0] next_data;
  int               cyc;
  int               n_cmp;
  int               n_fail;

  always #5 clk = ~clk;

  pipe_drain_buffer #(
    .WIDTH      (WIDTH),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .p_in_valid  (p_in_valid),
    .p_in_data   (p_in_data),
    .p_out_valid (p_out_valid),
    .p_out_data  (p_out_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .credits     (credits),
    .overflow    (overflow)
  );

  // External fixed-latency pipe; never reset, so stale data survives rst.
  always @(posedge clk) begin
    for (int i = LATENCY - 1; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    pv[0] <= p_in_valid;
    pd[0] <= p_in_data;
  end

  assign p_out_valid = pv[LATENCY-1] | inject;
  assign p_out_data  = inject ? inj_data : pd[LATENCY-1];

  function automatic bit ex_s_ready();
    return (since_rel >= LATENCY) && (mcred != 0);
  endfunction

  function automatic bit ex_m_valid();
    return fq.size() != 0;
  endfunction

  // Advance the model with this cycle's inputs, then move past the next edge.
  task automatic advance();
    bit run;
    m_fire = s_valid && ex_s_ready();
    m_pop  = ex_m_valid() && m_ready;
    if (rst) begin
      since_rel = 0;
      mcred     = DEPTH;
      fq.delete();
      movf   = 1'b0;
      m_fire = 1'b0;
      m_pop  = 1'b0;
    end else begin
      run = (since_rel >= LATENCY);
      if (m_pop) void'(fq.pop_front());
      if (run && p_out_valid === 1'b1) begin
        if (fq.size() < DEPTH) fq.push_back(p_out_data);
        else movf = 1'b1;
      end
      mcred = mcred - int'(m_fire) + int'(m_pop);
      if (!run) since_rel++;
      if (m_fire) next_data = next_data + 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    inject = 1'b0; inj_data = '0;
    repeat (2) begin
      @(negedge clk);
      advance();
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (s_ready !== (i >= LATENCY)) begin
        n_fail++;
        $display("FAIL reset_s_ready cyc=%0d i=%0d got=%b exp=%b", cyc, i, s_ready, (i >= LATENCY));
      end
      n_cmp++;
      if (credits !== CW'(DEPTH)) begin
        n_fail++;
        $display("FAIL reset_credits cyc=%0d got=%0d exp=%0d", cyc, credits, DEPTH);
      end
      n_cmp++;
      if (m_valid !== 1'b0 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flags cyc=%0d m_valid=%b overflow=%b exp=0/0", cyc, m_valid, overflow);
      end
      advance();
    end
  endtask

  task automatic test_streaming();
    int popped, exp_val, first_fire, first_mv, bad_ready;
    popped = 0; exp_val = 0; first_fire = -1; first_mv = -1; bad_ready = 0;
    next_data = '0;
    m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (popped >= 32) break;
      s_valid = (next_data < 8'h20);
      s_data  = next_data;
      @(negedge clk);
      n_cmp++;
      if (s_ready !== ex_s_ready() || credits !== CW'(mcred) || m_valid !== ex_m_valid()) begin
        n_fail++;
        $display("FAIL stream_ctrl cyc=%0d got rdy=%b cred=%0d mv=%b exp rdy=%b cred=%0d mv=%b",
                 cyc, s_ready, credits, m_valid, ex_s_ready(), mcred, ex_m_valid());
      end
      if (s_valid) begin
        n_cmp++;
        if (p_in_valid !== s_ready || p_in_data !== s_data) begin
          n_fail++;
          $display("FAIL stream_issue cyc=%0d got v=%b d=%h exp v=%b d=%h", cyc, p_in_valid, p_in_data, s_ready, s_data);
        end
        if (s_ready !== 1'b1) bad_ready++;
        if (s_ready === 1'b1 && first_fire < 0) first_fire = cyc;
      end
      if (m_valid === 1'b1) begin
        if (first_mv < 0) first_mv = cyc;
        n_cmp++;
        if (m_data !== WIDTH'(exp_val)) begin
          n_fail++;
          $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, m_data, WIDTH'(exp_val));
        end
        exp_val++;
        popped++;
      end
      advance();
    end
    s_valid = 1'b0;
    n_cmp++;
    if (popped != 32) begin
      n_fail++;
      $display("FAIL stream_count got=%0d exp=32", popped);
    end
    n_cmp++;
    if (first_mv - first_fire != LATENCY + 1) begin
      n_fail++;
      $display("FAIL stream_latency got=%0d exp=%0d", first_mv - first_fire, LATENCY + 1);
    end
    n_cmp++;
    if (bad_ready != 0) begin
      n_fail++;
      $display("FAIL stream_s_ready_drop got=%0d exp=0", bad_ready);
    end
  endtask

  task automatic test_backpressure();
    int fires, pops;
    fires = 0; pops = 0;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      s_data = next_data;
      @(negedge clk);
      n_cmp++;
      if (s_ready !== ex_s_ready() || credits !== CW'(mcred) || m_valid !== ex_m_valid() || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_fill cyc=%0d got rdy=%b cred=%0d mv=%b ovf=%b exp rdy=%b cred=%0d mv=%b ovf=0",
                 cyc, s_ready, credits, m_valid, overflow, ex_s_ready(), mcred, ex_m_valid());
      end
      if (p_in_valid === 1'b1) fires++;
      advance();
    end
    s_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fires != DEPTH) begin
      n_fail++;
      $display("FAIL bp_fire_count got=%0d exp=%0d", fires, DEPTH);
    end
    n_cmp++;
    if (credits !== '0 || s_ready !== 1'b0 || m_valid !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full got cred=%0d rdy=%b mv=%b ovf=%b exp 0/0/1/0", credits, s_ready, m_valid, overflow);
    end
    advance();
    m_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_cmp++;
      if (m_valid !== ex_m_valid() || credits !== CW'(mcred) || (ex_m_valid() && m_data !== fq[0])) begin
        n_fail++;
        $display("FAIL bp_drain cyc=%0d got mv=%b cred=%0d d=%h exp mv=%b cred=%0d",
                 cyc, m_valid, credits, m_data, ex_m_valid(), mcred);
      end
      if (m_valid === 1'b1) pops++;
      advance();
    end
    n_cmp++;
    if (pops != DEPTH || credits !== CW'(DEPTH)) begin
      n_fail++;
      $display("FAIL bp_return got pops=%0d cred=%0d exp pops=%0d cred=%0d", pops, credits, DEPTH, DEPTH);
    end
    s_valid = 1'b1;
    s_data  = next_data;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1 || p_in_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_resume got rdy=%b piv=%b exp 1/1", s_ready, p_in_valid);
    end
    advance();
    s_valid = 1'b0;
    repeat (LATENCY + 3) begin
      @(negedge clk);
      n_cmp++;
      if (m_valid !== ex_m_valid() || credits !== CW'(mcred) || (ex_m_valid() && m_data !== fq[0])) begin
        n_fail++;
        $display("FAIL bp_resume_drain cyc=%0d got mv=%b cred=%0d exp mv=%b cred=%0d", cyc, m_valid, credits, ex_m_valid(), mcred);
      end
      advance();
    end
  endtask

  task automatic test_random_wrap();
    int issued, popped;
    logic [WIDTH-1:0] pop_exp;
    issued = 0; popped = 0;
    pop_exp = next_data;
    for (int i = 0; i < 4000; i++) begin
      if (popped >= 200) break;
      s_valid = (issued < 200) && ($urandom_range(0, 3) != 0);
      s_data  = next_data;
      m_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
      n_cmp++;
      if (s_ready !== ex_s_ready() || credits !== CW'(mcred) || m_valid !== ex_m_valid()) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc=%0d got rdy=%b cred=%0d mv=%b exp rdy=%b cred=%0d mv=%b",
                 cyc, s_ready, credits, m_valid, ex_s_ready(), mcred, ex_m_valid());
      end
      if (m_valid === 1'b1 && m_ready) begin
        n_cmp++;
        if (m_data !== pop_exp) begin
          n_fail++;
          $display("FAIL rand_order cyc=%0d got=%h exp=%h", cyc, m_data, pop_exp);
        end
        pop_exp = pop_exp + 1'b1;
        popped++;
      end
      advance();
      if (m_fire) issued++;
    end
    s_valid = 1'b0;
    n_cmp++;
    if (popped != 200 || credits !== CW'(DEPTH)) begin
      n_fail++;
      $display("FAIL rand_total got popped=%0d cred=%0d exp 200/%0d", popped, credits, DEPTH);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] saved[$];
    int pops;
    pops = 0;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      s_data = next_data;
      @(negedge clk);
      n_cmp++;
      if (credits !== CW'(mcred) || m_valid !== ex_m_valid()) begin
        n_fail++;
        $display("FAIL ovf_fill cyc=%0d got cred=%0d mv=%b exp cred=%0d mv=%b", cyc, credits, m_valid, mcred, ex_m_valid());
      end
      advance();
    end
    s_valid = 1'b0;
    saved = fq;
    inject = 1'b1;
    inj_data = 8'hA5;
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b0 || credits !== '0) begin
      n_fail++;
      $display("FAIL ovf_before got ovf=%b cred=%0d exp 0/0", overflow, credits);
    end
    advance();
    inject = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (overflow !== 1'b1 || overflow !== movf || m_data !== saved[0]) begin
        n_fail++;
        $display("FAIL ovf_sticky cyc=%0d got ovf=%b d=%h exp ovf=1 d=%h", cyc, overflow, m_data, saved[0]);
      end
      advance();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        n_cmp++;
        if (saved.size() == 0 || m_data !== saved[0]) begin
          n_fail++;
          $display("FAIL ovf_contents cyc=%0d got=%h exp=%h left=%0d", cyc, m_data, (saved.size() != 0) ? saved[0] : 8'h00, saved.size());
        end
        if (saved.size() != 0) void'(saved.pop_front());
        pops++;
      end
      advance();
    end
    n_cmp++;
    if (pops != DEPTH || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_after_drain got pops=%0d ovf=%b exp %0d/1", pops, overflow, DEPTH);
    end
  endtask

  task automatic test_reset_midflight();
    int fires, guard, mv_seen;
    fires = 0; guard = 0; mv_seen = 0;
    m_ready = 1'b0;
    while (fires < 8 && guard < 30) begin
      s_valid = 1'b1;
      s_data  = next_data;
      @(negedge clk);
      n_cmp++;
      if (s_ready !== ex_s_ready() || credits !== CW'(mcred) || overflow !== movf) begin
        n_fail++;
        $display("FAIL mid_issue cyc=%0d got rdy=%b cred=%0d ovf=%b exp rdy=%b cred=%0d ovf=%b",
                 cyc, s_ready, credits, overflow, ex_s_ready(), mcred, movf);
      end
      advance();
      if (m_fire) fires++;
      guard++;
    end
    s_valid = 1'b0;
    guard = 0;
    while (fq.size() < 3 && guard < 20) begin
      @(negedge clk);
      advance();
      guard++;
    end
    @(negedge clk);
    n_cmp++;
    if (fires != 8 || fq.size() != 3 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup got fires=%0d buffered=%0d mv=%b exp 8/3/1", fires, fq.size(), m_valid);
    end
    rst = 1'b1;
    advance();
    @(negedge clk);
    advance();
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0) mv_seen++;
      n_cmp++;
      if (s_ready !== (i >= LATENCY) || credits !== CW'(DEPTH) || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_after_rst cyc=%0d i=%0d got rdy=%b cred=%0d ovf=%b exp rdy=%b cred=%0d ovf=0",
                 cyc, i, s_ready, credits, overflow, (i >= LATENCY), DEPTH);
      end
      advance();
    end
    n_cmp++;
    if (mv_seen != 0) begin
      n_fail++;
      $display("FAIL mid_stale_visible got=%0d cycles with m_valid exp=0", mv_seen);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    since_rel = 0; mcred = DEPTH; movf = 1'b0; next_data = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_random_wrap();
    test_overflow();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
